// File: rtl/clink_pkg.sv
// ============================================================================
//  Module      : clink_pkg
//  Description : Shared types, constants and helpers for the Camera Link
//                frame packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FRAME   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam int c_FRAME_CNT_W = 32;
    localparam int c_DROP_CNT_W  = 16;

    // Number of tap-groups that fit in one output beat.
    function automatic int groups_per_beat(input int out_w, input int taps, input int pix_w);
        return out_w / (taps * pix_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clink_sync_fifo.sv
// ============================================================================
//  Module      : clink_sync_fifo
//  Description : Show-ahead synchronous FIFO with full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clink_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("clink_sync_fifo: DEPTH must be a power of two and at least 4");
    end

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wptr;
    logic [c_ADDR_W-1:0] r_rptr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_rd;
    logic                w_wr;

    // A simultaneous read frees the slot, so a write into a full FIFO is accepted.
    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
            else if (w_rd && !w_wr) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wr_data;
    end

    assign o_full    = (r_count == (c_ADDR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

endmodule

`default_nettype wire

// File: rtl/clink_frame_packer.sv
// ============================================================================
//  Module      : clink_frame_packer
//  Description : Camera Link ROI crop and pixel packer onto AXI4-Stream.
//                Define CLINK_TEST_PATTERN_EN to add the cfg_test_pattern port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clink_frame_packer
    import clink_pkg::*;
#(
    parameter int TAPS        = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int OUT_WIDTH   = 128,
    parameter int FIFO_DEPTH  = 16,
    parameter int COORD_WIDTH = 12
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic                        cfg_enable,
    input  logic [COORD_WIDTH-1:0]      cfg_x_start,
    input  logic [COORD_WIDTH-1:0]      cfg_x_size,
    input  logic [COORD_WIDTH-1:0]      cfg_y_start,
    input  logic [COORD_WIDTH-1:0]      cfg_y_size,
`ifdef CLINK_TEST_PATTERN_EN
    input  logic                        cfg_test_pattern,
`endif
    input  logic                        fval,
    input  logic                        lval,
    input  logic                        dval,
    input  logic [TAPS*PIXEL_WIDTH-1:0] pix_data,
    output logic [OUT_WIDTH-1:0]        m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic [c_FRAME_CNT_W-1:0]    frame_count,
    output logic [c_DROP_CNT_W-1:0]     drop_count,
    output logic                        overflow,
    output logic                        busy
);

    localparam int c_GRP_W  = TAPS * PIXEL_WIDTH;
    localparam int c_GROUPS = groups_per_beat(OUT_WIDTH, TAPS, PIXEL_WIDTH);
    localparam int c_SLOT_W = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;
    localparam int c_ROI_W  = COORD_WIDTH + 1;
    localparam logic [c_SLOT_W-1:0] c_LAST_SLOT = c_SLOT_W'(c_GROUPS - 1);

    if ((OUT_WIDTH % c_GRP_W) != 0) begin : g_bad_width
        $error("clink_frame_packer: OUT_WIDTH must be a multiple of TAPS*PIXEL_WIDTH");
    end

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 last;
        logic                 user;
    } beat_t;

    state_t                   r_state;
    logic                     r_fval, r_fval_d, r_lval, r_lval_d, r_dval;
    logic [c_GRP_W-1:0]       r_pix;
    logic [COORD_WIDTH-1:0]   r_col, r_row;
    logic [c_ROI_W-1:0]       r_x_start, r_x_end, r_y_start, r_y_end;
    logic [OUT_WIDTH-1:0]     r_acc;
    logic [c_SLOT_W-1:0]      r_slot;
    logic                     r_first, r_produced, r_beat_vld, r_overflow;
    beat_t                    r_beat;
    logic [c_FRAME_CNT_W-1:0] r_frame_cnt;
    logic [c_DROP_CNT_W-1:0]  r_drop_cnt;

    logic w_fval_rise, w_fval_fall, w_lval_rise, w_lval_fall;
    logic w_keep, w_full_grp, w_flush, w_emit, w_last_col;
    logic w_wr_try, w_rd, w_ovf, w_fifo_full, w_fifo_empty;
    logic [COORD_WIDTH-1:0] w_col;
    logic [c_ROI_W-1:0]     w_col_ext, w_row_ext;
    logic [c_GRP_W-1:0]     w_grp;
    logic [OUT_WIDTH-1:0]   w_acc_ins;
    beat_t                  w_wr_beat, w_rd_beat;

    assign w_fval_rise = r_fval & ~r_fval_d;
    assign w_fval_fall = ~r_fval & r_fval_d;
    assign w_lval_rise = r_lval & ~r_lval_d;
    assign w_lval_fall = ~r_lval & r_lval_d;

    assign w_col     = w_lval_rise ? '0 : r_col;
    assign w_col_ext = {1'b0, w_col};
    assign w_row_ext = {1'b0, r_row};

    assign w_keep = (r_state == ST_FRAME) && r_lval && r_dval &&
                    (w_col_ext >= r_x_start) && (w_col_ext < r_x_end) &&
                    (w_row_ext >= r_y_start) && (w_row_ext < r_y_end);
    assign w_full_grp = w_keep && (r_slot == c_LAST_SLOT);
    assign w_flush    = (r_state == ST_FRAME) && w_lval_fall && (r_slot != '0);
    assign w_emit     = w_full_grp || w_flush;
    assign w_last_col = ((w_col_ext + 1'b1) == r_x_end);

`ifdef CLINK_TEST_PATTERN_EN
    logic               r_tp;
    logic [c_GRP_W-1:0] w_tp_grp;
    for (genvar t = 0; t < TAPS; t++) begin : g_tp
        assign w_tp_grp[t*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(int'(w_col) * TAPS + t);
    end
    assign w_grp = r_tp ? w_tp_grp : r_pix;
`else
    assign w_grp = r_pix;
`endif

    always_comb begin
        w_acc_ins = r_acc;
        w_acc_ins[r_slot*c_GRP_W +: c_GRP_W] = w_grp;
    end

    // A full beat still queued when its line ends (ROI wider than the line) gets tlast here.
    always_comb begin
        w_wr_beat      = r_beat;
        w_wr_beat.last = r_beat.last | w_lval_fall;
    end

    assign w_wr_try = r_beat_vld && (r_state != ST_DISCARD);
    assign w_rd     = m_axis_tready && !w_fifo_empty;
    assign w_ovf    = w_wr_try && w_fifo_full && !w_rd;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state     <= ST_IDLE;
            // Treat FVAL as already high so a frame in progress at release is not joined.
            r_fval      <= 1'b1;
            r_fval_d    <= 1'b1;
            r_lval      <= 1'b0;
            r_lval_d    <= 1'b0;
            r_dval      <= 1'b0;
            r_pix       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_x_start   <= '0;
            r_x_end     <= '0;
            r_y_start   <= '0;
            r_y_end     <= '0;
            r_acc       <= '0;
            r_slot      <= '0;
            r_first     <= 1'b0;
            r_produced  <= 1'b0;
            r_beat      <= '0;
            r_beat_vld  <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
`ifdef CLINK_TEST_PATTERN_EN
            r_tp        <= 1'b0;
`endif
        end else begin
            r_fval   <= fval;
            r_fval_d <= r_fval;
            r_lval   <= lval;
            r_lval_d <= r_lval;
            r_dval   <= dval;
            r_pix    <= pix_data;

            if (w_lval_rise)          r_col <= r_dval ? COORD_WIDTH'(1) : '0;
            else if (r_lval && r_dval) r_col <= r_col + 1'b1;
            if (w_lval_fall)          r_row <= r_row + 1'b1;

            r_beat_vld <= 1'b0;
            if (w_emit) begin
                r_beat.data <= w_full_grp ? w_acc_ins : r_acc;
                r_beat.last <= w_full_grp ? w_last_col : 1'b1;
                r_beat.user <= r_first;
                r_beat_vld  <= 1'b1;
                r_acc       <= '0;
                r_slot      <= '0;
                r_first     <= 1'b0;
                r_produced  <= 1'b1;
            end else if (w_keep) begin
                r_acc  <= w_acc_ins;
                r_slot <= r_slot + 1'b1;
            end

            if (w_ovf) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fval_rise && cfg_enable) begin
                        r_state    <= ST_FRAME;
                        r_row      <= '0;
                        r_acc      <= '0;
                        r_slot     <= '0;
                        r_first    <= 1'b1;
                        r_produced <= 1'b0;
                        r_x_start  <= {1'b0, cfg_x_start};
                        r_x_end    <= {1'b0, cfg_x_start} + {1'b0, cfg_x_size};
                        r_y_start  <= {1'b0, cfg_y_start};
                        r_y_end    <= {1'b0, cfg_y_start} + {1'b0, cfg_y_size};
`ifdef CLINK_TEST_PATTERN_EN
                        r_tp       <= cfg_test_pattern;
`endif
                    end
                end
                ST_FRAME: begin
                    if (w_fval_fall) begin
                        r_state <= ST_IDLE;
                        if ((r_produced || w_emit) && !w_ovf) r_frame_cnt <= r_frame_cnt + 1'b1;
                    end else if (w_ovf) begin
                        r_state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (w_fval_fall) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    clink_sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (s_axi_aclk),
        .rst_n     (s_axi_aresetn),
        .i_wr_en   (w_wr_try),
        .i_wr_data (w_wr_beat),
        .o_full    (w_fifo_full),
        .i_rd_en   (m_axis_tready),
        .o_rd_data (w_rd_beat),
        .o_empty   (w_fifo_empty)
    );

    assign m_axis_tdata  = w_rd_beat.data;
    assign m_axis_tlast  = w_rd_beat.last;
    assign m_axis_tuser  = w_rd_beat.user;
    assign m_axis_tvalid = !w_fifo_empty;
    assign frame_count   = r_frame_cnt;
    assign drop_count    = r_drop_cnt;
    assign overflow      = r_overflow;
    assign busy          = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_clink_frame_packer.sv
// ============================================================================
//  Module      : tb_clink_frame_packer
//  Description : Scoreboard testbench for clink_frame_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clink_frame_packer;

    localparam int TAPS = 4;
    localparam int PW   = 8;
    localparam int OW   = 128;
    localparam int CW   = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_enable;
    logic [CW-1:0]   cfg_x_start, cfg_x_size, cfg_y_start, cfg_y_size;
    logic            cfg_test_pattern;
    logic            fval, lval, dval;
    logic [31:0]     pix_data;
    logic [OW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [31:0]     frame_count;
    logic [15:0]     drop_count;
    logic            overflow, busy;

    always #5 clk = ~clk;

    clink_frame_packer #(
        .TAPS(TAPS), .PIXEL_WIDTH(PW), .OUT_WIDTH(OW), .FIFO_DEPTH(16), .COORD_WIDTH(CW)
    ) dut (
        .s_axi_aclk       (clk),
        .s_axi_aresetn    (rst_n),
        .cfg_enable       (cfg_enable),
        .cfg_x_start      (cfg_x_start),
        .cfg_x_size       (cfg_x_size),
        .cfg_y_start      (cfg_y_start),
        .cfg_y_size       (cfg_y_size),
`ifdef CLINK_TEST_PATTERN_EN
        .cfg_test_pattern (cfg_test_pattern),
`endif
        .fval             (fval),
        .lval             (lval),
        .dval             (dval),
        .pix_data         (pix_data),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .frame_count      (frame_count),
        .drop_count       (drop_count),
        .overflow         (overflow),
        .busy             (busy)
    );

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    checks   = 0;
    int    failures = 0;
    int    beat_idx = 0;

    // Pixel byte = line*32 + col*4 + tap (mod 256).
    function automatic logic [31:0] grp(input int l, input int c);
        logic [31:0] g;
        for (int t = 0; t < TAPS; t++) g[t*8 +: 8] = 8'(l*32 + c*4 + t);
        return g;
    endfunction

    function automatic logic [OW-1:0] beat4(input int l, input int c0);
        return {grp(l, c0+3), grp(l, c0+2), grp(l, c0+1), grp(l, c0)};
    endfunction

    task automatic push(input logic [OW-1:0] d, input logic last, input logic user);
        beat_t b;
        b.data = d;
        b.last = last;
        b.user = user;
        exp_q.push_back(b);
    endtask

    task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got data=%h last=%b user=%b, expected no beat",
                         m_axis_tdata, m_axis_tlast, m_axis_tuser);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_axis_tdata !== mon_exp.data || m_axis_tlast !== mon_exp.last ||
                    m_axis_tuser !== mon_exp.user) begin
                    failures++;
                    $display("FAIL beat_%0d: got data=%h last=%b user=%b, expected data=%h last=%b user=%b",
                             beat_idx, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                             mon_exp.data, mon_exp.last, mon_exp.user);
                end
            end
            beat_idx++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_roi(input int xs, input int xz, input int ys, input int yz);
        cfg_x_start = CW'(xs);
        cfg_x_size  = CW'(xz);
        cfg_y_start = CW'(ys);
        cfg_y_size  = CW'(yz);
    endtask

    task automatic send_line(input int l, input int ng);
        for (int c = 0; c < ng; c++) begin
            lval = 1'b1; dval = 1'b1; pix_data = grp(l, c);
            step();
        end
        lval = 1'b0; dval = 1'b0; pix_data = '0;
        step(); step(); step();
    endtask

    task automatic send_frame(input int nl, input int ng);
        fval = 1'b1;
        step(); step();
        for (int l = 0; l < nl; l++) send_line(l, ng);
        fval = 1'b0;
        step(); step(); step(); step();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = budget;
        while (exp_q.size() != 0 && n > 0) begin
            step();
            n--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d beats outstanding, expected 0", name, exp_q.size());
        end
        repeat (5) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_enable = 1'b1; cfg_test_pattern = 1'b0;
        set_roi(0, 4, 0, 2);
        fval = 1'b0; lval = 1'b0; dval = 1'b0; pix_data = '0; m_axis_tready = 1'b1;
        step(); step(); step();

        chk("reset_tvalid", OW'(m_axis_tvalid), '0);
        chk("reset_tdata", m_axis_tdata, '0);
        chk("reset_busy", OW'(busy), '0);
        chk("reset_frame_count", OW'(frame_count), '0);
        chk("reset_drop_count", OW'(drop_count), '0);
        chk("reset_overflow", OW'(overflow), '0);
        rst_n = 1'b1;
        step(); step();

        // Two lines of four groups, full ROI.
        set_roi(0, 4, 0, 2);
        push(beat4(0, 0), 1'b1, 1'b1);
        push(beat4(1, 0), 1'b1, 1'b0);
        send_frame(2, 4);
        wait_drain("basic_drain", 50);
        chk("basic_frame_count", OW'(frame_count), OW'(1));

        // Column crop: groups 1..4 full beat, group 5 alone in a partial beat.
        set_roi(1, 5, 0, 2);
        for (int l = 0; l < 2; l++) begin
            push(beat4(l, 1), 1'b0, (l == 0));
            push({96'h0, grp(l, 5)}, 1'b1, 1'b0);
        end
        send_frame(2, 8);
        wait_drain("crop_drain", 50);
        chk("crop_frame_count", OW'(frame_count), OW'(2));

        // Stalled sink: 20 beats into a 16-deep FIFO.
        m_axis_tready = 1'b0;
        set_roi(0, 4, 0, 20);
        for (int l = 0; l < 16; l++) push(beat4(l, 0), 1'b1, (l == 0));
        send_frame(20, 4);
        chk("ovf_tvalid", OW'(m_axis_tvalid), OW'(1));
        chk("ovf_head_hold", m_axis_tdata, beat4(0, 0));
        chk("ovf_overflow", OW'(overflow), OW'(1));
        chk("ovf_drop_count", OW'(drop_count), OW'(1));
        chk("ovf_frame_count", OW'(frame_count), OW'(2));
        chk("ovf_busy", OW'(busy), '0);
        m_axis_tready = 1'b1;
        wait_drain("ovf_drain", 100);
        set_roi(0, 4, 0, 1);
        push(beat4(0, 0), 1'b1, 1'b1);
        send_frame(1, 4);
        wait_drain("post_ovf_drain", 50);
        chk("post_ovf_frame_count", OW'(frame_count), OW'(3));

        // Disabled at frame start, enabled mid-frame: frame must be skipped.
        cfg_enable = 1'b0;
        fval = 1'b1;
        step(); step();
        cfg_enable = 1'b1;
        step();
        send_line(0, 4);
        chk("disabled_busy", OW'(busy), '0);
        fval = 1'b0;
        repeat (8) step();
        chk("disabled_tvalid", OW'(m_axis_tvalid), '0);
        chk("disabled_frame_count", OW'(frame_count), OW'(3));
        push(beat4(0, 0), 1'b1, 1'b1);
        send_frame(1, 4);
        wait_drain("reenable_drain", 50);
        chk("reenable_frame_count", OW'(frame_count), OW'(4));

        // Reset mid-line with three beats queued.
        m_axis_tready = 1'b0;
        set_roi(0, 4, 0, 10);
        fval = 1'b1;
        step(); step();
        for (int l = 0; l < 3; l++) send_line(l, 4);
        lval = 1'b1; dval = 1'b1; pix_data = grp(3, 0); step();
        pix_data = grp(3, 1); step();
        chk("pre_reset_tvalid", OW'(m_axis_tvalid), OW'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset_tvalid", OW'(m_axis_tvalid), '0);
        chk("midreset_frame_count", OW'(frame_count), '0);
        chk("midreset_overflow", OW'(overflow), '0);
        chk("midreset_drop_count", OW'(drop_count), '0);
        pix_data = grp(3, 2); step(); step();
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        pix_data = grp(3, 3); step();
        lval = 1'b0; dval = 1'b0; pix_data = '0; step(); step();
        send_line(4, 4);
        fval = 1'b0;
        repeat (8) step();
        chk("joined_tvalid", OW'(m_axis_tvalid), '0);
        chk("joined_busy", OW'(busy), '0);
        chk("joined_frame_count", OW'(frame_count), '0);
        set_roi(0, 4, 0, 1);
        push(beat4(0, 0), 1'b1, 1'b1);
        send_frame(1, 4);
        wait_drain("post_reset_drain", 50);
        chk("post_reset_frame_count", OW'(frame_count), OW'(1));

`ifdef CLINK_TEST_PATTERN_EN
        cfg_test_pattern = 1'b1;
        set_roi(0, 4, 0, 1);
        push(128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1, 1'b1);
        send_frame(1, 4);
        wait_drain("pattern_drain", 50);
        cfg_test_pattern = 1'b0;
`endif

        repeat (10) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
